mips_multicycle_cpu: RTL and testbench

Multi-cycle successor to the single-cycle MIPS CPU. It executes the same 32-bit MIPS subset through a state machine, one phase per clock, and reuses one ALU for PC increment, address generation and arithmetic. Instruction fetch and data access share one unified memory port with a ready handshake, so slow or wait-stated memories can be attached. Instruction and data memories are external to the block.

---
 rtl/mips_multicycle_cpu.sv | 278 +++++++++++++++++++++++++++
 tb/tb_mips_multicycle_cpu.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_cpu.sv
// Multi-cycle MIPS subset core: one phase per clock, a single shared ALU and
// one unified request/ready memory port for fetch and data access.
module mips_multicycle_cpu #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        retire,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] aluout_q, aluout_d;
  logic [31:0] mdr_q, mdr_d;
  logic        halted_q, halted_d;
  logic [31:0] rf_q [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext_imm;
  logic        legal;

  logic [31:0] rf_rs, rf_rt;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [31:0] alu_a, alu_b, alu_y;
  alu_op_t     alu_op;

  logic        req, we;
  logic [31:2] addr_w;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};

  assign rf_rs = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rf_rt = (rt == 5'd0) ? '0 : rf_q[rt];

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_JR, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
          default:                                      legal = 1'b0;
        endcase
      end
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
      default:                                     legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD: alu_y = alu_a + alu_b;
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    halted_d = halted_q;
    alu_a    = pc_q;
    alu_b    = 32'd4;
    alu_op   = ALU_ADD;
    req      = 1'b0;
    we       = 1'b0;
    addr_w   = pc_q[31:2];
    retire   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = aluout_q;

    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = alu_y;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        a_d      = rf_rs;
        b_d      = rf_rt;
        alu_b    = {sext_imm[29:0], 2'b00};
        aluout_d = alu_y;
        if (opcode == OP_J) begin
          pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (!legal) begin
          if (HALT_ON_ILLEGAL) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_a   = a_q;
        alu_b   = b_q;
        state_d = S_FETCH;
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_JR) begin
              pc_d   = a_q;
              retire = 1'b1;
            end else begin
              case (funct)
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
              endcase
              aluout_d = alu_y;
              state_d  = S_WB;
            end
          end
          OP_ADDI: begin
            alu_b    = sext_imm;
            aluout_d = alu_y;
            state_d  = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_b    = sext_imm;
            aluout_d = alu_y;
            state_d  = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            // Branch target was precomputed into ALUOut during DECODE.
            if ((a_q == b_q) == (opcode == OP_BEQ)) pc_d = aluout_q;
            retire = 1'b1;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        req    = 1'b1;
        we     = (opcode == OP_SW);
        addr_w = aluout_q[31:2];
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we = 1'b1;
        case (opcode)
          OP_ADDI: begin
            rf_waddr = rt;
            rf_wdata = aluout_q;
          end
          OP_LW: begin
            rf_waddr = rt;
            rf_wdata = mdr_q;
          end
          default: begin
            rf_waddr = rd;
            rf_wdata = aluout_q;
          end
        endcase
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
      halted_q <= halted_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Gating with rst drops an in-flight request the instant reset asserts.
  assign mem_req   = req & rst;
  assign mem_we    = we & rst;
  assign mem_addr  = {addr_w, 2'b00};
  assign mem_wdata = b_q;
  assign pc        = pc_q;
  assign instr     = ir_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Directed bench: runs a small MIPS program from a wait-stated memory model and
// checks cycle counts, PC, bus behaviour and stored register values.
module tb_mips_multicycle_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, instr;

  logic        rst2;
  logic        mem_req2, mem_we2, retire2, halted2;
  logic [31:0] mem_addr2, mem_wdata2, pc2, instr2;

  always #5 clk = ~clk;

  mips_multicycle_cpu #(.RESET_PC(32'h0000_0000), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .instr(instr), .retire(retire), .halted(halted)
  );

  // Second core fed a constant illegal opcode with zero-wait memory.
  mips_multicycle_cpu #(.RESET_PC(32'h0000_0000), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst(rst2),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(32'hFC00_0000), .mem_ready(mem_req2),
    .pc(pc2), .instr(instr2), .retire(retire2), .halted(halted2)
  );

  logic [31:0] mem [0:511];
  int unsigned wcnt;
  int unsigned fetch_delay, data_delay;
  logic        ld_en;
  logic [8:0]  ld_idx;
  logic [31:0] ld_data;
  logic        is_data;

  assign is_data   = (mem_addr >= 32'h200) && (mem_addr < 32'h400);
  assign mem_rdata = mem[mem_addr[10:2]];
  assign mem_ready = mem_req && (wcnt >= (is_data ? data_delay : fetch_delay));

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
    else if (mem_req && mem_we && mem_ready) mem[mem_addr[10:2]] <= mem_wdata;
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  int checks = 0;
  int failures = 0;
  int unsigned we_cnt;
  logic [31:0] we_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int unsigned a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_idx  = a[10:2];
    ld_data = d;
    next_cycle();
    ld_en   = 1'b0;
  endtask

  // Counts cycles from the current (first) cycle of an instruction up to its
  // retire cycle, then steps past the retiring edge.
  task automatic run_instr(input string tag, input int unsigned exp_cyc);
    int unsigned cyc;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (mem_we === 1'b1) begin
        we_cnt++;
        we_addr = mem_addr;
      end
      if (retire === 1'b1) break;
      next_cycle();
    end
    check(tag, cyc, exp_cyc);
    next_cycle();
  endtask

  logic [31:0] prog [0:16];
  logic [31:0] prog_hi [0:5];

  initial begin
    int unsigned bad;
    int unsigned rcnt;
    int unsigned cyc2;

    prog = '{32'h2001_0005, 32'h2022_FFF9, 32'hAC02_0200, 32'h8C03_0200,
             32'hAC03_0204, 32'hAC01_0208, 32'h0041_202A, 32'hAC04_020C,
             32'h1021_0002, 32'hFC00_0000, 32'hFC00_0000, 32'h1421_0002,
             32'h0021_0020, 32'hAC00_0210, 32'h2005_0080, 32'h0041_3022,
             32'h0800_0100};
    prog_hi = '{32'hAC06_0214, 32'h0041_3824, 32'h0041_4025, 32'hAC07_0218,
                32'hAC08_021C, 32'h00A0_0008};

    rst = 1'b0; rst2 = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    fetch_delay = 0; data_delay = 0; we_cnt = 0; we_addr = '0;
    next_cycle();
    next_cycle();

    for (int i = 0; i < 17; i++) load(32'(i) * 4, prog[i]);
    for (int i = 0; i < 6; i++) load(32'h400 + 32'(i) * 4, prog_hi[i]);
    load(32'h80, 32'hFC00_0000);
    for (int i = 0; i < 16; i++) load(32'h200 + 32'(i) * 4, 32'hDEAD_BEEF);

    check("rst_pc", pc, 32'h0);
    check("rst_ir", instr, 32'h0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    rst = 1'b1;
    #1;
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", mem_addr, 32'h0);

    run_instr("addi1_cyc", 4);
    run_instr("addi2_cyc", 4);
    check("pc_after_addi", pc, 32'h8);

    data_delay = 3;
    we_cnt = 0;
    run_instr("sw_wait_cyc", 7);
    check("sw_we_cycles", we_cnt, 32'd4);
    check("sw_addr", we_addr, 32'h200);
    check("sw_data", mem[128], 32'hFFFF_FFFE);
    run_instr("lw_wait_cyc", 8);
    data_delay = 0;

    run_instr("sw3_cyc", 4);
    check("lw_value", mem[129], 32'hFFFF_FFFE);
    run_instr("sw1_cyc", 4);
    check("addi_value", mem[130], 32'h5);
    run_instr("slt_cyc", 4);
    run_instr("sw4_cyc", 4);
    check("slt_value", mem[131], 32'h1);

    run_instr("beq_cyc", 3);
    check("beq_pc", pc, 32'h2C);
    run_instr("bne_cyc", 3);
    check("bne_pc", pc, 32'h30);

    run_instr("add0_cyc", 4);
    run_instr("sw0_cyc", 4);
    check("r0_value", mem[132], 32'h0);
    run_instr("addi5_cyc", 4);
    run_instr("sub_cyc", 4);

    run_instr("j_cyc", 2);
    check("j_pc", pc, 32'h400);
    check("j_ir", instr, 32'h0800_0100);
    run_instr("sw6_cyc", 4);
    check("sub_value", mem[133], 32'hFFFF_FFF9);
    run_instr("and_cyc", 4);
    run_instr("or_cyc", 4);
    run_instr("sw7_cyc", 4);
    run_instr("sw8_cyc", 4);
    check("and_value", mem[134], 32'h4);
    check("or_value", mem[135], 32'hFFFF_FFFF);

    run_instr("jr_cyc", 3);
    check("jr_pc", pc, 32'h80);

    bad = 0;
    rcnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (retire === 1'b1) rcnt++;
      if (i >= 1 && mem_req !== 1'b0) bad++;
      next_cycle();
    end
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_no_retire", rcnt, 32'd0);
    check("halt_no_req", bad, 32'd0);

    load(32'h200, 32'hDEAD_BEEF);
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    #1;
    data_delay = 5;
    run_instr("re_addi1_cyc", 4);
    run_instr("re_addi2_cyc", 4);
    next_cycle();
    next_cycle();
    next_cycle();
    check("mid_we", 32'(mem_we), 32'd1);
    check("mid_req", 32'(mem_req), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_req", 32'(mem_req), 32'd0);
    check("abort_we", 32'(mem_we), 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #1;
    check("restart_pc", pc, 32'h0);
    check("restart_req", 32'(mem_req), 32'd1);
    check("restart_addr", mem_addr, 32'h0);
    check("abort_no_store", mem[128], 32'hDEAD_BEEF);
    data_delay = 0;
    fetch_delay = 2;
    run_instr("fetch_wait_cyc", 6);
    fetch_delay = 0;

    rst2 = 1'b1;
    #1;
    for (cyc2 = 1; cyc2 <= 20; cyc2++) begin
      if (retire2 === 1'b1) break;
      next_cycle();
    end
    check("nop_illegal_cyc", cyc2, 32'd2);
    next_cycle();
    check("nop_pc", pc2, 32'h4);
    check("nop_ir", instr2, 32'hFC00_0000);
    check("nop_halted", 32'(halted2), 32'd0);
    check("nop_fetch_addr", mem_addr2, 32'h4);
    check("nop_we", 32'(mem_we2), 32'd0);
    check("nop_wdata", mem_wdata2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
